// File: rtl/mux_4_way_rr_feeder.sv
// Round-robin scheduler driving the 4-way mux select; captures the selected word for downstream.
// Select on E0, capture and one-cycle grant on E1; the word is held in HOLD until out_ready, with no new selection meanwhile.
module mux_4_way_rr_feeder #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       req,
  output logic [3:0]       grant,
  output logic [1:0]       sel,
  input  logic [WIDTH-1:0] mux_out,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SELECT = 2'd1,
    HOLD   = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [1:0]       sel_q, sel_d;
  logic [1:0]       last_q, last_d;
  logic [3:0]       grant_q, grant_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             valid_q, valid_d;

  logic [1:0]       pick;
  logic [1:0]       cand;
  logic             found;

  // Search starts one past the last winner and wraps, so last itself is checked last.
  always_comb begin
    pick  = last_q;
    cand  = 2'b00;
    found = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      cand = last_q + 2'(k);
      if (!found && req[cand]) begin
        pick  = cand;
        found = 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    last_d  = last_q;
    grant_d = grant_q;
    data_d  = data_q;
    valid_d = valid_q;
    case (state_q)
      IDLE: begin
        if (found) begin
          sel_d   = pick;
          state_d = SELECT;
        end
      end
      SELECT: begin
        data_d  = mux_out;
        valid_d = 1'b1;
        grant_d = 4'b0001 << sel_q;
        last_d  = sel_q;
        state_d = HOLD;
      end
      HOLD: begin
        grant_d = 4'b0000;
        if (valid_q && out_ready) begin
          valid_d = 1'b0;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sel_q   <= 2'b00;
      last_q  <= 2'b11;
      grant_q <= 4'b0000;
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      last_q  <= last_d;
      grant_q <= grant_d;
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign grant     = grant_q;
  assign sel       = sel_q;
  assign out_data  = data_q;
  assign out_valid = valid_q;

endmodule
